// File: rtl/fft_out_reorder_if.sv
// Stream interface for fft_out_reorder: bit-reversed input samples in,
// natural-order bins out. The slave modport is the reorder buffer; the
// master modport is the upstream/downstream side.
interface fft_out_reorder_if #(
  parameter int unsigned DW    = 24,
  parameter int unsigned LOG2N = 10
);
  logic                    in_valid;
  logic signed [DW-1:0]    din_r;
  logic signed [DW-1:0]    din_i;
  logic                    out_valid;
  logic signed [DW-1:0]    dout_r;
  logic signed [DW-1:0]    dout_i;
  logic        [LOG2N-1:0] out_index;
  logic                    frame_start;
  logic                    frame_last;

  modport master (
    output in_valid, din_r, din_i,
    input  out_valid, dout_r, dout_i, out_index, frame_start, frame_last
  );

  modport slave (
    input  in_valid, din_r, din_i,
    output out_valid, dout_r, dout_i, out_index, frame_start, frame_last
  );
endinterface

// File: rtl/fft_out_reorder.sv
// Output reorder buffer for the 1024-point radix-2 SDF FFT.
// Writes the bit-reversed sample stream into one of two ping-pong banks at
// address bitrev(wcnt) and drains the other bank in natural bin order as a
// gapless valid-qualified stream.
// Optional build macro: FFT_REORDER_SCALE_EN -- when defined, each output
// component is normalised by 1/N with round-half-up; otherwise data passes
// through unchanged. Latency is the same in both builds.
module fft_out_reorder #(
  parameter int unsigned N_POINTS = 1024,
  parameter int unsigned LOG2N    = 10,
  parameter int unsigned DW       = 24
) (
  input logic              clk,
  input logic              rst,
  fft_out_reorder_if.slave bus
);

  localparam int unsigned      MemDepth = 2 * N_POINTS;
  localparam logic [LOG2N-1:0] LastIdx  = LOG2N'(N_POINTS - 1);

  typedef enum logic [0:0] {StIdle, StDrain} state_e;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] res;
    for (int unsigned b = 0; b < LOG2N; b++) begin
      res[b] = a[LOG2N-1-b];
    end
    return res;
  endfunction

`ifdef FFT_REORDER_SCALE_EN
  localparam logic signed [DW:0] RndHalf = (DW+1)'(2 ** (LOG2N - 1));

  // One extra bit of headroom so the rounding add cannot wrap.
  function automatic logic signed [DW-1:0] scale(input logic signed [DW-1:0] x);
    logic signed [DW:0] sum;
    logic signed [DW:0] sh;
    sum = $signed({x[DW-1], x}) + RndHalf;
    sh  = sum >>> LOG2N;
    return sh[DW-1:0];
  endfunction
`endif

  // Sample storage: bank select is the MSB of the address.
  logic [2*DW-1:0] r_mem [MemDepth];

  logic [LOG2N-1:0] r_wcnt;
  logic             r_wbank;
  logic             r_rd_req;
  state_e           r_state;
  logic [LOG2N-1:0] r_rcnt;

  logic                    r_out_valid;
  logic signed [DW-1:0]    r_dout_r;
  logic signed [DW-1:0]    r_dout_i;
  logic        [LOG2N-1:0] r_out_index;
  logic                    r_frame_start;
  logic                    r_frame_last;

  logic                 w_wrap;
  logic [LOG2N:0]       w_waddr;
  logic [LOG2N:0]       w_raddr;
  logic [2*DW-1:0]      w_rdata;
  logic signed [DW-1:0] w_rd_r;
  logic signed [DW-1:0] w_rd_i;
  logic signed [DW-1:0] w_dout_r;
  logic signed [DW-1:0] w_dout_i;
  state_e               w_state_d;
  logic [LOG2N-1:0]     w_rcnt_d;
  logic                 w_rd_en;
  logic                 w_consume;
  logic                 w_rd_req_d;

  assign w_wrap  = bus.in_valid && (r_wcnt == LastIdx);
  assign w_waddr = {r_wbank, bitrev(r_wcnt)};
  assign w_raddr = {~r_wbank, r_rcnt};
  assign w_rdata = r_mem[w_raddr];
  assign w_rd_r  = w_rdata[2*DW-1:DW];
  assign w_rd_i  = w_rdata[DW-1:0];

  // Bank write: storage is not reset, stale contents are never read out.
  always_ff @(posedge clk) begin
    if (bus.in_valid) begin
      r_mem[w_waddr] <= {bus.din_r, bus.din_i};
    end
  end

  // Write counter and bank toggle on frame wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wcnt  <= '0;
      r_wbank <= 1'b0;
    end else if (bus.in_valid) begin
      r_wcnt <= r_wcnt + 1'b1;
      if (w_wrap) begin
        r_wbank <= ~r_wbank;
      end
    end
  end

  // Read FSM next state. The request cycle itself performs the first read so
  // bin 0 is presented one edge after the frame's last sample.
  always_comb begin
    w_state_d = r_state;
    w_rcnt_d  = r_rcnt;
    w_rd_en   = 1'b0;
    w_consume = 1'b0;
    case (r_state)
      StIdle: begin
        if (r_rd_req) begin
          w_rd_en   = 1'b1;
          w_consume = 1'b1;
          w_rcnt_d  = r_rcnt + 1'b1;
          w_state_d = StDrain;
        end
      end
      StDrain: begin
        w_rd_en  = 1'b1;
        w_rcnt_d = r_rcnt + 1'b1;
        if (r_rcnt == LastIdx) begin
          if (r_rd_req) begin
            w_consume = 1'b1;
          end else begin
            w_state_d = StIdle;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
    // A new wrap always wins over consuming the previous request.
    w_rd_req_d = w_wrap ? 1'b1 : (w_consume ? 1'b0 : r_rd_req);
  end

  // Read FSM state, read counter and pending-frame request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= StIdle;
      r_rcnt   <= '0;
      r_rd_req <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_rcnt   <= w_rcnt_d;
      r_rd_req <= w_rd_req_d;
    end
  end

  // Optional 1/N normalisation of the read data.
  always_comb begin
`ifdef FFT_REORDER_SCALE_EN
    w_dout_r = scale(w_rd_r);
    w_dout_i = scale(w_rd_i);
`else
    w_dout_r = w_rd_r;
    w_dout_i = w_rd_i;
`endif
  end

  // Registered outputs; data and index hold when no read is in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid   <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_last  <= 1'b0;
      r_dout_r      <= '0;
      r_dout_i      <= '0;
      r_out_index   <= '0;
    end else begin
      r_out_valid   <= w_rd_en;
      r_frame_start <= w_rd_en && (r_rcnt == '0);
      r_frame_last  <= w_rd_en && (r_rcnt == LastIdx);
      if (w_rd_en) begin
        r_dout_r    <= w_dout_r;
        r_dout_i    <= w_dout_i;
        r_out_index <= r_rcnt;
      end
    end
  end

  assign bus.out_valid   = r_out_valid;
  assign bus.dout_r      = r_dout_r;
  assign bus.dout_i      = r_dout_i;
  assign bus.out_index   = r_out_index;
  assign bus.frame_start = r_frame_start;
  assign bus.frame_last  = r_frame_last;

endmodule

// File: doc/fft_out_reorder.md
# fft_out_reorder

Output reorder buffer for the 1024-point radix-2 SDF FFT pipeline. It consumes the bit-reversed-order sample stream leaving the last butterfly/delay-line stage and emits the same frame in natural bin order (bin 0..1023) as a gapless valid-qualified stream. It uses two ping-pong banks, so one frame is written while the previous frame is read out. It is the read-side counterpart of the pipeline's delay-line writers and sits between the final FFT stage and the system output.

## Interface
- `N_POINTS`, default 1024: frame length. Must be a power of two.
- `LOG2N`, default 10: log2(N_POINTS), the address width.
- `DW`, default 24: signed sample width per component.

Ports:
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  reset, asynchronous, active-high.
- `in_valid`  input  1  qualifies `din_r`/`din_i` this cycle. May have gaps.
- `din_r`  input  DW  signed real part, bit-reversed order.
- `din_i`  input  DW  signed imaginary part, bit-reversed order.
- `out_valid`  output  1  `dout_*` and `out_index` are valid.
- `dout_r`  output  DW  signed real part, natural order.
- `dout_i`  output  DW  signed imaginary part, natural order.
- `out_index`  output  LOG2N  bin number of the current output.
- `frame_start`  output  1  high with `out_index`==0.
- `frame_last`  output  1  high with `out_index`==N_POINTS-1.

## Operation
- Storage: two banks, each N_POINTS x (2*DW).
  - `wbank` selects the bank being written. The other bank is the read bank.
- Write side:
  - `wcnt` (LOG2N bits) increments on each `in_valid`.
  - Sample is stored at address bitrev(`wcnt`) in `wbank`.
  - When `wcnt` wraps from N_POINTS-1 to 0: `wbank` toggles and `rd_req` is set.
- Read side states:
  - IDLE: wait for `rd_req`.
  - DRAIN: `rcnt` runs 0..N_POINTS-1, one per cycle with no stalls, reading the bank not selected by `wbank`. After `rcnt`==N_POINTS-1 it returns to IDLE, or goes straight to DRAIN of the next bank if `rd_req` is set again that cycle.
- Outputs are registered.
  - `out_index` = `rcnt` delayed to align with the data.
- Throughput guarantee: a fill needs at least N_POINTS cycles and a drain takes exactly N_POINTS cycles, so the read bank is never overwritten. No backpressure and no overflow path.
- Simultaneous events: a write wrap in the same cycle as the final DRAIN read causes a seamless back-to-back frame. `out_valid` stays high and `frame_last` is followed directly by `frame_start`.
- `in_valid` low holds `wcnt`. The read side is unaffected.

## Timing
- Reset values: `out_valid`, `frame_start`, `frame_last` = 0; `dout_r`, `dout_i`, `out_index` = 0. Internally, `wcnt`, `rcnt`, `wbank`, `rd_req` = 0 and the state is IDLE.
- Reset mid-frame: the partial write frame and any in-progress drain are discarded. No output until a full new frame is written.
- Latency: last sample of a frame accepted at edge E. Then `out_valid`=1 with `out_index`=0 after edge E+1, continuing for N_POINTS consecutive cycles.
- Outside DRAIN output, `out_valid`=0 and `dout_*` hold their last value.

## Configuration
- `FFT_REORDER_SCALE_EN` defined: output = (din + 2^(LOG2N-1)) >>> LOG2N per component.
  - This is 1/N normalization with round-half-up, and the result is sign-extended to DW bits.
  - No saturation is needed.
- Not defined: the data passes through unchanged.
- Latency is identical in both cases.

## Test plan
- Ramp: after reset, feed 1024 samples where sample k has `din_r`=bitrev(k) and `din_i`=-bitrev(k).
  - Expect 1024 consecutive outputs with `dout_r`=`out_index`=n and `dout_i`=-n.
  - `frame_start` is high at n=0 and `frame_last` at n=1023.
  - The first output appears one cycle after the last input.
- Back-to-back: feed 3 gapless frames with distinct offsets (+0, +4096, +8192).
  - Expect 3072 contiguous `out_valid` cycles, correct per-frame data, and no gap between frames.
- Bursty input: `in_valid` random at 50% duty.
  - Output is still gapless within each frame.
  - Data matches the ramp check.
- Reset mid-frame: assert `rst` after 500 samples, then feed a full frame.
  - Expect no output for the first 500 samples; only the new frame is output.
  - Also assert `rst` during a drain: `out_valid` drops to 0 immediately.
- Scale build (`FFT_REORDER_SCALE_EN`): input 1023 → output 1; input 511 → 0; input 512 → 1; input -513 → -1; input -8388608 → -8192.
- Unscaled build: inputs 8388607 and -8388608 pass through unchanged.
